qbus_ram_slave: RTL and testbench

- Q-bus responder (slave) for the LSI-11 processor's bus cycles.
- Decodes the address latched at SYNC and answers DATI, DATO, DATOB and DATIO(B) cycles with RPLY from a local word RAM, with byte-write support.
- Optionally answers interrupt-acknowledge (IAKI) cycles with a programmable vector.
- Sits on the inverted Q-bus pins beside the processor wrapper, in bench/system top levels.

---
 rtl/qbus_ram_slave.sv | 263 ++++++++++++++++++++++++++
 tb/tb_qbus_ram_slave.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbus_ram_slave.sv
// qbus_ram_slave: Q-bus responder backed by a local word RAM with byte writes.
// Define QBUS_VEC_EN to add the interrupt request / IAK vector responder.
module qbus_ram_slave #(
  parameter logic [15:0] BASE     = 16'o160000,
  parameter int          AW       = 6,
  parameter int          WAIT_CYC = 2,
  parameter logic [15:0] VECTOR   = 16'o000300
) (
  input  logic        pin_clk,
  input  logic        mc_clr_aclo,
  input  logic        pin_init_n,
  input  logic        pin_sync_n,
  input  logic        pin_din_n,
  input  logic        pin_dout_n,
  input  logic        pin_wtbt_n,
  inout  wire  [15:0] pin_ad_n,
  output logic        pin_rply_n,
  input  logic        pin_iaki_n,
  output logic        pin_iako_n,
  output logic        pin_virq_n,
  input  logic        irq_set,
  output logic [3:0]  dbg_state
);

  // Bus handshake: a strobe (DIN/DOUT) is acknowledged by RPLY once the data is
  // valid/taken; RPLY is held until the strobe drops, then released.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_SKIP = 4'd1,
    S_SEL  = 4'd2,
    S_RD   = 4'd3,
    S_RDH  = 4'd4,
    S_RDE  = 4'd5,
    S_WR   = 4'd6,
    S_WRH  = 4'd7,
    S_VEC  = 4'd8,
    S_VECH = 4'd9
  } state_t;

  localparam bit         NO_WAIT  = (WAIT_CYC == 0);
  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  logic [5:0]    raw_in;
  logic [5:0]    s1;
  logic [5:0]    s2;
  logic          sync_q;
  logic [15:0]   ad_s1;
  logic          sync_s, din_s, dout_s, wtbt_s, iaki_s, init_s;
  logic          match;
  logic          wr_go;
  logic          vec_req;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW:0]   addr;
  logic [AW-1:0] idx;
  logic          rply_q;
  logic          ad_oe;
  logic [15:0]   ad_out;

  logic [15:0]   mem [2**AW];

  assign raw_in = ~{pin_init_n, pin_iaki_n, pin_wtbt_n, pin_dout_n, pin_din_n, pin_sync_n};

  always_ff @(posedge pin_clk or posedge mc_clr_aclo) begin
    if (mc_clr_aclo) begin
      s1     <= '0;
      s2     <= '0;
      sync_q <= 1'b0;
      ad_s1  <= '0;
    end else begin
      s1     <= raw_in;
      s2     <= s1;
      sync_q <= s2[0];
      ad_s1  <= ~pin_ad_n;
    end
  end

  assign sync_s = s2[0];
  assign din_s  = s2[1];
  assign dout_s = s2[2];
  assign wtbt_s = s2[3];
  assign iaki_s = s2[4];
  assign init_s = s2[5];

  assign match = (ad_s1[15:AW+1] == BASE[15:AW+1]);
  assign idx   = addr[AW:1];

  // The write lands on the edge that leaves SEL for a DOUT, so it is committed
  // even if SYNC is later dropped mid-cycle.
  assign wr_go = (state == S_SEL) && sync_s && !din_s && dout_s && !init_s;

  always_ff @(posedge pin_clk) begin
    if (wr_go) begin
      if (!wtbt_s)
        mem[idx] <= ad_s1;
      else if (addr[0])
        mem[idx][15:8] <= ad_s1[7:0];
      else
        mem[idx][7:0] <= ad_s1[7:0];
    end
  end

  always_ff @(posedge pin_clk or posedge mc_clr_aclo) begin
    if (mc_clr_aclo) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      addr   <= '0;
      rply_q <= 1'b0;
      ad_oe  <= 1'b0;
      ad_out <= '0;
    end else if (init_s) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      rply_q <= 1'b0;
      ad_oe  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sync_s && !sync_q) begin
            addr  <= ad_s1[AW:0];
            state <= match ? S_SEL : S_SKIP;
          end else if (vec_req) begin
            ad_out <= VECTOR;
            ad_oe  <= 1'b1;
            cnt    <= CNT_INIT;
            if (NO_WAIT) begin
              rply_q <= 1'b1;
              state  <= S_VECH;
            end else begin
              state <= S_VEC;
            end
          end
        end
        S_SKIP: begin
          if (!sync_s) state <= S_IDLE;
        end
        S_SEL: begin
          if (!sync_s) begin
            state <= S_IDLE;
          end else if (din_s) begin
            ad_out <= mem[idx];
            ad_oe  <= 1'b1;
            cnt    <= CNT_INIT;
            if (NO_WAIT) begin
              rply_q <= 1'b1;
              state  <= S_RDH;
            end else begin
              state <= S_RD;
            end
          end else if (dout_s) begin
            cnt <= CNT_INIT;
            if (NO_WAIT) begin
              rply_q <= 1'b1;
              state  <= S_WRH;
            end else begin
              state <= S_WR;
            end
          end
        end
        S_RD, S_WR: begin
          if (!sync_s) begin
            rply_q <= 1'b0;
            ad_oe  <= 1'b0;
            state  <= S_IDLE;
          end else if (cnt == 4'd0) begin
            rply_q <= 1'b1;
            state  <= (state == S_RD) ? S_RDH : S_WRH;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RDH: begin
          if (!sync_s) begin
            rply_q <= 1'b0;
            ad_oe  <= 1'b0;
            state  <= S_IDLE;
          end else if (!din_s) begin
            rply_q <= 1'b0;
            state  <= S_RDE;
          end
        end
        S_RDE: begin
          // Data stays on the bus one extra clock for master hold time.
          ad_oe <= 1'b0;
          state <= S_SEL;
        end
        S_WRH: begin
          if (!sync_s) begin
            rply_q <= 1'b0;
            ad_oe  <= 1'b0;
            state  <= S_IDLE;
          end else if (!dout_s) begin
            rply_q <= 1'b0;
            state  <= S_SEL;
          end
        end
        S_VEC: begin
          if (!din_s) begin
            ad_oe <= 1'b0;
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            rply_q <= 1'b1;
            state  <= S_VECH;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_VECH: begin
          if (!din_s) begin
            rply_q <= 1'b0;
            ad_oe  <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          rply_q <= 1'b0;
          ad_oe  <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign pin_rply_n = rply_q ? 1'b0 : 1'bz;
  assign pin_ad_n   = ad_oe ? ~ad_out : 16'hzzzz;
  assign dbg_state  = state;

`ifdef QBUS_VEC_EN
  logic pending;
  logic iako_q;

  assign vec_req = pending && din_s && iaki_s && !sync_s && (state == S_IDLE);

  // IAKI is only forwarded down the chain while we have nothing to claim.
  always_ff @(posedge pin_clk or posedge mc_clr_aclo) begin
    if (mc_clr_aclo) begin
      pending <= 1'b0;
      iako_q  <= 1'b0;
    end else if (init_s) begin
      pending <= 1'b0;
      iako_q  <= 1'b0;
    end else begin
      if (irq_set)
        pending <= 1'b1;
      else if (vec_req)
        pending <= 1'b0;
      iako_q <= iaki_s && !pending && !vec_req && (state != S_VEC) && (state != S_VECH);
    end
  end

  assign pin_virq_n = pending ? 1'b0 : 1'bz;
  assign pin_iako_n = ~iako_q;
`else
  logic unused_vec;

  assign vec_req    = 1'b0;
  assign pin_virq_n = 1'bz;
  assign pin_iako_n = pin_iaki_n;
  assign unused_vec = irq_set ^ iaki_s;
`endif

endmodule

// File: tb/tb_qbus_ram_slave.sv
// Directed bench for qbus_ram_slave: acts as the Q-bus master with hand-computed
// expectations for latency, data, byte lanes, decode, DATIO, INIT and reset.
module tb_qbus_ram_slave;
  logic        pin_clk = 1'b0;
  logic        mc_clr_aclo = 1'b1;
  logic        pin_init_n = 1'b1;
  logic        pin_sync_n = 1'b1;
  logic        pin_din_n = 1'b1;
  logic        pin_dout_n = 1'b1;
  logic        pin_wtbt_n = 1'b1;
  logic        pin_iaki_n = 1'b1;
  logic        irq_set = 1'b0;
  wire  [15:0] pin_ad_n;
  wire         pin_rply_n;
  wire         pin_iako_n;
  wire         pin_virq_n;
  logic [3:0]  dbg_state;

  logic [15:0] m_ad = 16'h0;
  logic        m_ad_oe = 1'b0;

  int checks = 0;
  int passed = 0;

  assign pin_ad_n = m_ad_oe ? ~m_ad : 16'hzzzz;

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (pin_ad_n[g]);
  end
  pullup (pin_rply_n);
  pullup (pin_virq_n);

  always #5 pin_clk = ~pin_clk;

  qbus_ram_slave dut (
    .pin_clk    (pin_clk),
    .mc_clr_aclo(mc_clr_aclo),
    .pin_init_n (pin_init_n),
    .pin_sync_n (pin_sync_n),
    .pin_din_n  (pin_din_n),
    .pin_dout_n (pin_dout_n),
    .pin_wtbt_n (pin_wtbt_n),
    .pin_ad_n   (pin_ad_n),
    .pin_rply_n (pin_rply_n),
    .pin_iaki_n (pin_iaki_n),
    .pin_iako_n (pin_iako_n),
    .pin_virq_n (pin_virq_n),
    .irq_set    (irq_set),
    .dbg_state  (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pin_clk);
    #1;
  endtask

  task automatic addr_phase(input logic [15:0] a);
    m_ad = a;
    m_ad_oe = 1'b1;
    tick();
    pin_sync_n = 1'b0;
    repeat (4) tick();
    m_ad_oe = 1'b0;
  endtask

  task automatic end_cycle();
    pin_sync_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic wait_rply(output int n);
    n = 0;
    while (pin_rply_n !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (pin_rply_n !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic byte_op,
                          output int lat, output int rel);
    addr_phase(a);
    m_ad = d;
    m_ad_oe = 1'b1;
    pin_wtbt_n = byte_op ? 1'b0 : 1'b1;
    tick();
    pin_dout_n = 1'b0;
    wait_rply(lat);
    pin_dout_n = 1'b1;
    wait_release(rel);
    m_ad_oe = 1'b0;
    pin_wtbt_n = 1'b1;
    end_cycle();
  endtask

  task automatic do_read(input logic [15:0] a, output logic [15:0] d, output int lat, output int rel);
    addr_phase(a);
    pin_din_n = 1'b0;
    wait_rply(lat);
    d = ~pin_ad_n;
    pin_din_n = 1'b1;
    wait_release(rel);
    end_cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mc_clr_aclo = 1'b1;
    repeat (3) tick();
    mc_clr_aclo = 1'b0;
    repeat (3) tick();
    checks++; if (pin_rply_n !== 1'b1) $display("FAIL reset_rply: got %b want 1", pin_rply_n); else passed++;
    checks++; if (pin_ad_n !== 16'hffff) $display("FAIL reset_ad: got %h want ffff", pin_ad_n); else passed++;
    checks++; if (pin_virq_n !== 1'b1) $display("FAIL reset_virq: got %b want 1", pin_virq_n); else passed++;
    checks++; if (pin_iako_n !== 1'b1) $display("FAIL reset_iako: got %b want 1", pin_iako_n); else passed++;
    checks++; if (dbg_state !== 4'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else passed++;
  endtask

  task automatic test_word();
    int lat, rel;
    logic [15:0] d;
    do_write(16'o160010, 16'o123456, 1'b0, lat, rel);
    checks++; if (lat !== 5) $display("FAIL dato_latency: got %0d want 5", lat); else passed++;
    checks++; if (rel > 3) $display("FAIL dato_release: got %0d want <=3", rel); else passed++;
    do_read(16'o160010, d, lat, rel);
    checks++; if (lat !== 5) $display("FAIL dati_latency: got %0d want 5", lat); else passed++;
    checks++; if (d !== 16'o123456) $display("FAIL dati_data: got %o want 123456", d); else passed++;
    checks++; if (rel > 3) $display("FAIL dati_release: got %0d want <=3", rel); else passed++;
  endtask

  task automatic test_byte();
    int lat, rel;
    logic [15:0] d;
    do_write(16'o160020, 16'o177777, 1'b0, lat, rel);
    do_write(16'o160021, 16'o000252, 1'b1, lat, rel);
    checks++; if (lat !== 5) $display("FAIL datob_latency: got %0d want 5", lat); else passed++;
    do_read(16'o160020, d, lat, rel);
    checks++; if (d !== 16'o125377) $display("FAIL byte_high: got %o want 125377", d); else passed++;
    do_write(16'o160020, 16'o000125, 1'b1, lat, rel);
    do_read(16'o160020, d, lat, rel);
    checks++; if (d !== 16'o125125) $display("FAIL byte_low: got %o want 125125", d); else passed++;
  endtask

  task automatic test_nomatch();
    logic [15:0] addrs [2];
    addrs[0] = 16'o157776;
    addrs[1] = 16'o164000;
    for (int k = 0; k < 2; k++) begin
      logic saw_rply, saw_ad;
      saw_rply = 1'b0;
      saw_ad = 1'b0;
      addr_phase(addrs[k]);
      pin_din_n = 1'b0;
      for (int t = 0; t < 20; t++) begin
        tick();
        if (pin_rply_n !== 1'b1) saw_rply = 1'b1;
        if (pin_ad_n !== 16'hffff) saw_ad = 1'b1;
      end
      checks++; if (saw_rply) $display("FAIL nomatch_rply addr %o: got rply want none", addrs[k]); else passed++;
      checks++; if (saw_ad) $display("FAIL nomatch_ad addr %o: got driven want released", addrs[k]); else passed++;
      checks++; if (dbg_state !== 4'd1) $display("FAIL nomatch_state addr %o: got %0d want 1", addrs[k], dbg_state); else passed++;
      pin_din_n = 1'b1;
      end_cycle();
    end
  endtask

  task automatic test_datio();
    int lat, rel;
    logic [15:0] d;
    do_write(16'o160004, 16'o000000, 1'b0, lat, rel);
    addr_phase(16'o160004);
    pin_din_n = 1'b0;
    wait_rply(lat);
    d = ~pin_ad_n;
    checks++; if (lat !== 5) $display("FAIL datio_rd_latency: got %0d want 5", lat); else passed++;
    checks++; if (d !== 16'o000000) $display("FAIL datio_rd_data: got %o want 0", d); else passed++;
    pin_din_n = 1'b1;
    wait_release(rel);
    repeat (2) tick();
    m_ad = 16'o000001;
    m_ad_oe = 1'b1;
    tick();
    pin_dout_n = 1'b0;
    wait_rply(lat);
    checks++; if (lat !== 5) $display("FAIL datio_wr_latency: got %0d want 5", lat); else passed++;
    pin_dout_n = 1'b1;
    wait_release(rel);
    m_ad_oe = 1'b0;
    end_cycle();
    do_read(16'o160004, d, lat, rel);
    checks++; if (d !== 16'o000001) $display("FAIL datio_readback: got %o want 1", d); else passed++;
  endtask

  task automatic test_init();
    int lat, rel;
    logic [15:0] d;
    addr_phase(16'o160010);
    pin_din_n = 1'b0;
    wait_rply(lat);
    checks++; if (lat !== 5) $display("FAIL init_pre_latency: got %0d want 5", lat); else passed++;
    pin_init_n = 1'b0;
    repeat (3) tick();
    checks++; if (pin_rply_n !== 1'b1) $display("FAIL init_rply: got %b want 1", pin_rply_n); else passed++;
    checks++; if (pin_ad_n !== 16'hffff) $display("FAIL init_ad: got %h want ffff", pin_ad_n); else passed++;
    checks++; if (dbg_state !== 4'd0) $display("FAIL init_state: got %0d want 0", dbg_state); else passed++;
    pin_init_n = 1'b1;
    pin_din_n = 1'b1;
    end_cycle();
    do_read(16'o160010, d, lat, rel);
    checks++; if (lat !== 5) $display("FAIL post_init_latency: got %0d want 5", lat); else passed++;
    checks++; if (d !== 16'o123456) $display("FAIL post_init_data: got %o want 123456", d); else passed++;
  endtask

  task automatic test_aclo_wr();
    int lat, rel;
    logic [15:0] d;
    addr_phase(16'o160030);
    m_ad = 16'o000007;
    m_ad_oe = 1'b1;
    tick();
    pin_dout_n = 1'b0;
    wait_rply(lat);
    checks++; if (lat !== 5) $display("FAIL aclo_pre_latency: got %0d want 5", lat); else passed++;
    #2;
    mc_clr_aclo = 1'b1;
    #1;
    checks++; if (pin_rply_n !== 1'b1) $display("FAIL aclo_rply: got %b want 1", pin_rply_n); else passed++;
    checks++; if (dbg_state !== 4'd0) $display("FAIL aclo_state: got %0d want 0", dbg_state); else passed++;
    m_ad_oe = 1'b0;
    #1;
    checks++; if (pin_ad_n !== 16'hffff) $display("FAIL aclo_ad: got %h want ffff", pin_ad_n); else passed++;
    pin_dout_n = 1'b1;
    pin_sync_n = 1'b1;
    tick();
    mc_clr_aclo = 1'b0;
    repeat (4) tick();
    do_read(16'o160030, d, lat, rel);
    checks++; if (d !== 16'o000007) $display("FAIL aclo_committed: got %o want 7", d); else passed++;
  endtask

`ifdef QBUS_VEC_EN
  task automatic test_vector();
    int lat, rel, n;
    logic [15:0] d;
    irq_set = 1'b1;
    tick();
    irq_set = 1'b0;
    tick();
    checks++; if (pin_virq_n !== 1'b0) $display("FAIL vec_virq_set: got %b want 0", pin_virq_n); else passed++;
    pin_iaki_n = 1'b0;
    pin_din_n = 1'b0;
    wait_rply(lat);
    d = ~pin_ad_n;
    checks++; if (lat !== 5) $display("FAIL vec_latency: got %0d want 5", lat); else passed++;
    checks++; if (d !== 16'o000300) $display("FAIL vec_data: got %o want 300", d); else passed++;
    checks++; if (pin_iako_n !== 1'b1) $display("FAIL vec_iako_blocked: got %b want 1", pin_iako_n); else passed++;
    pin_din_n = 1'b1;
    pin_iaki_n = 1'b1;
    wait_release(rel);
    checks++; if (rel > 3) $display("FAIL vec_release: got %0d want <=3", rel); else passed++;
    checks++; if (pin_virq_n !== 1'b1) $display("FAIL vec_virq_clear: got %b want 1", pin_virq_n); else passed++;
    repeat (4) tick();
    pin_iaki_n = 1'b0;
    n = 0;
    while (pin_iako_n !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n !== 3) $display("FAIL iak_pass_latency: got %0d want 3", n); else passed++;
    pin_iaki_n = 1'b1;
    repeat (4) tick();
    checks++; if (pin_iako_n !== 1'b1) $display("FAIL iak_pass_release: got %b want 1", pin_iako_n); else passed++;
  endtask
`else
  task automatic test_vector();
    irq_set = 1'b1;
    tick();
    irq_set = 1'b0;
    repeat (3) tick();
    checks++; if (pin_virq_n !== 1'b1) $display("FAIL novec_virq: got %b want 1", pin_virq_n); else passed++;
    pin_iaki_n = 1'b0;
    #1;
    checks++; if (pin_iako_n !== 1'b0) $display("FAIL novec_iako_low: got %b want 0", pin_iako_n); else passed++;
    pin_iaki_n = 1'b1;
    #1;
    checks++; if (pin_iako_n !== 1'b1) $display("FAIL novec_iako_high: got %b want 1", pin_iako_n); else passed++;
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_nomatch();
    test_datio();
    test_init();
    test_aclo_wr();
    test_vector();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
